// File: rtl/hog_cell_hist.sv
// rtl/hog_cell_hist.sv - HOG cell histogram: orientation binning and 9-bin magnitude accumulation
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   sample valid            in_ready   block can accept a sample
//   magnitude  unsigned Q(MAG_I).(MAG_F) gradient magnitude
//   tan        unsigned Q(TAN_W-16).16 |dy/dx|, saturated when dx=0
//   negative   gradient angle lies in 90-180 degrees
//   out_valid  histogram valid         out_ready  downstream accepts the histogram
//   hist       9 bins, bin k at [k*HIST_W +: HIST_W]
//
// Optional feature macro: HOG_HIST_INT_EN (round magnitudes to integers before accumulation)
module hog_cell_hist #(
  parameter int MAG_I    = 9,
  parameter int MAG_F    = 16,
  parameter int TAN_W    = 19,
  parameter int CELL_PIX = 64,
  localparam int MAG_W   = MAG_I + MAG_F,
  localparam int CNT_W   = $clog2(CELL_PIX),
`ifdef HOG_HIST_INT_EN
  localparam int ADD_W   = MAG_I,
`else
  localparam int ADD_W   = MAG_W,
`endif
  localparam int HIST_W  = ADD_W + CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MAG_W-1:0]      magnitude,
  input  logic [TAN_W-1:0]      tan,
  input  logic                  negative,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [9*HIST_W-1:0]   hist
);

  // tan(20/40/60/80 degrees) in Q.16
  localparam logic [TAN_W-1:0] T20 = TAN_W'(23853);
  localparam logic [TAN_W-1:0] T40 = TAN_W'(54991);
  localparam logic [TAN_W-1:0] T60 = TAN_W'(113512);
  localparam logic [TAN_W-1:0] T80 = TAN_W'(371673);

  typedef enum logic {ACCUM, OUTPUT} state_t;

  state_t            state;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [CNT_W-1:0]  cnt;
  logic [HIST_W-1:0] acc [9];

  logic [3:0]        bin_sel;
  logic [2:0]        sector;
  logic [ADD_W-1:0]  add_val;

  // Sector 0..4 counts how many thresholds tan has reached; the negative
  // half-plane mirrors the sector around bin 4 (the vertical direction).
  always_comb begin
    sector = 3'd4;
    if (tan < T20)      sector = 3'd0;
    else if (tan < T40) sector = 3'd1;
    else if (tan < T60) sector = 3'd2;
    else if (tan < T80) sector = 3'd3;
    bin_sel = negative ? (4'd8 - {1'b0, sector}) : {1'b0, sector};
  end

`ifdef HOG_HIST_INT_EN
  logic [MAG_W:0] rnd_sum;
  logic [MAG_I:0] rnd_int;

  // Half-up rounding; the carry out of the integer field saturates to all ones.
  always_comb begin
    rnd_sum = {1'b0, magnitude} + (MAG_W + 1)'(1 << (MAG_F - 1));
    rnd_int = (MAG_I + 1)'(rnd_sum >> MAG_F);
    add_val = rnd_int[MAG_I] ? {ADD_W{1'b1}} : rnd_int[MAG_I-1:0];
  end
`else
  always_comb begin
    add_val = magnitude;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ACCUM;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cnt         <= '0;
      for (int k = 0; k < 9; k++) acc[k] <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid && in_ready_q) begin
            for (int k = 0; k < 9; k++) begin
              if (bin_sel == 4'(k)) acc[k] <= acc[k] + HIST_W'(add_val);
            end
            // Counter wraps naturally since CELL_PIX is a power of two.
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(CELL_PIX - 1)) begin
              state       <= OUTPUT;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            for (int k = 0; k < 9; k++) acc[k] <= '0;
            state       <= ACCUM;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= ACCUM;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

  for (genvar g = 0; g < 9; g++) begin : g_hist
    assign hist[g*HIST_W +: HIST_W] = acc[g];
  end

endmodule

// File: tb/tb_hog_cell_hist.sv
// tb/tb_hog_cell_hist.sv - self-checking bench for hog_cell_hist against a threshold-rule model
module tb_hog_cell_hist;

  localparam int MAG_I    = 9;
  localparam int MAG_F    = 16;
  localparam int TAN_W    = 19;
  localparam int CELL_PIX = 64;
  localparam int MAG_W    = MAG_I + MAG_F;
  localparam int CNT_W    = $clog2(CELL_PIX);
`ifdef HOG_HIST_INT_EN
  localparam int HIST_W   = MAG_I + CNT_W;
`else
  localparam int HIST_W   = MAG_W + CNT_W;
`endif
  localparam int TIMEOUT  = 200;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [MAG_W-1:0]     magnitude;
  logic [TAN_W-1:0]     tan;
  logic                 negative;
  logic                 out_valid;
  logic                 out_ready;
  logic [9*HIST_W-1:0]  hist;

  int n_vec = 0;
  int n_err = 0;

  longint exp_bin [9];
  int     thr [4] = '{23853, 54991, 113512, 371673};

  hog_cell_hist #(
    .MAG_I(MAG_I), .MAG_F(MAG_F), .TAN_W(TAN_W), .CELL_PIX(CELL_PIX)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .magnitude(magnitude), .tan(tan), .negative(negative),
    .out_valid(out_valid), .out_ready(out_ready),
    .hist(hist)
  );

  always #5 clk = ~clk;

  // Bin = number of 20-degree boundaries the angle has passed, mirrored for 90-180.
  function automatic int ref_bin(input int t, input bit neg);
    int s = 0;
    for (int i = 0; i < 4; i++) if (t >= thr[i]) s++;
    return neg ? 8 - s : s;
  endfunction

  function automatic longint ref_contrib(input longint m);
`ifdef HOG_HIST_INT_EN
    longint r = (m + 64'd32768) / 65536;
    return (r > 511) ? 511 : r;
`else
    return m;
`endif
  endfunction

  function automatic longint get_bin(input int k);
    return longint'(hist[k*HIST_W +: HIST_W]);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 9; k++) exp_bin[k] = 0;
  endtask

  task automatic check_bins(input string name);
    for (int k = 0; k < 9; k++) begin
      n_vec++;
      if (get_bin(k) !== exp_bin[k]) begin
        n_err++;
        $display("FAIL %s bin%0d: got %0d expected %0d", name, k, get_bin(k), exp_bin[k]);
      end
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  // Drive one sample and wait (bounded) for its acceptance; leaves in_valid low at posedge+1.
  task automatic push(input int m, input int t, input bit neg);
    int waited = 0;
    in_valid  = 1'b1;
    magnitude = MAG_W'(m);
    tan       = TAN_W'(t);
    negative  = neg;
    @(negedge clk);
    while (!in_ready && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (in_ready !== 1'b0 || out_valid === 1'b1 || waited < TIMEOUT)
      exp_bin[ref_bin(t, neg)] += ref_contrib(longint'(m));
  endtask

  // Wait for the histogram, check it, then handshake after `delay` extra cycles.
  task automatic take_cell(input string name, input int delay);
    int waited = 0;
    @(negedge clk);
    while (!out_valid && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    check_bit({name, "_out_valid"}, out_valid, 1'b1);
    check_bit({name, "_in_ready_low"}, in_ready, 1'b0);
    check_bins(name);
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      check_bit({name, "_hold_valid"}, out_valid, 1'b1);
      check_bins({name, "_hold"});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    model_clear();
    check_bit({name, "_ready_back"}, in_ready, 1'b1);
    check_bit({name, "_valid_drop"}, out_valid, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    magnitude = '0; tan = '0; negative = 1'b0;
    #1;
    model_clear();
    check_bit("reset_in_ready", in_ready, 1'b1);
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_bins("reset_hist");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    longint want;
`ifdef HOG_HIST_INT_EN
    want = 64;
`else
    want = 4194304;
`endif
    for (int i = 0; i < CELL_PIX; i++) begin
      push(32'h10000, 0, 1'b0);
      if (i == CELL_PIX - 2) check_bit("basic_no_early_valid", out_valid, 1'b0);
    end
    check_bit("basic_valid_next_cycle", out_valid, 1'b1);
    n_vec++;
    if (get_bin(0) !== want) begin
      n_err++;
      $display("FAIL basic_bin0_const: got %0d expected %0d", get_bin(0), want);
    end
    take_cell("basic", 0);
  endtask

  task automatic test_boundary();
    int tb_tans [4] = '{23852, 23853, 371672, 371673};
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < 4; i++) push(32'h10000, tb_tans[i], n[0]);
      for (int i = 4; i < CELL_PIX; i++) push(0, int'($urandom_range(0, 524287)), $urandom_range(0, 1) == 1);
      take_cell(n == 0 ? "boundary_pos" : "boundary_neg", 0);
    end
  endtask

  task automatic test_saturated();
    for (int i = 0; i < CELL_PIX; i++) push(32'h20000, 32'h7FFFF, 1'b1);
    take_cell("saturated", 1);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < CELL_PIX; i++) push(int'($urandom_range(0, 33554431)), int'($urandom_range(0, 524287)), $urandom_range(0, 1) == 1);
    in_valid = 1'b1; magnitude = MAG_W'(32'h30000); tan = TAN_W'(200000); negative = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_bit("bp_in_ready_low", in_ready, 1'b0);
      check_bins("bp_hold");
      @(posedge clk);
    end
    #1 out_ready = 1'b1;
    @(negedge clk);
    check_bins("bp_before_hs");
    @(posedge clk);
    #1 out_ready = 1'b0;
    model_clear();
    check_bit("bp_ready_after", in_ready, 1'b1);
    check_bins("bp_cleared");
    push(32'h30000, 200000, 1'b1);
    for (int i = 1; i < CELL_PIX; i++) push(0, 0, 1'b0);
    take_cell("bp_next_cell", 0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) push(32'h10000, 60000, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    model_clear();
    check_bins("midrst_async");
    check_bit("midrst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < CELL_PIX; i++) push(32'h10000, 60000, 1'b1);
    take_cell("midrst_cell", 0);
  endtask

  task automatic test_random();
    int picks [11] = '{0, 23852, 23853, 54990, 54991, 113511, 113512, 371672, 371673, 524287, 1000};
    int m, t;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < CELL_PIX; i++) begin
        case ($urandom_range(0, 3))
          0: m = 0;
          1: m = 33554431;
          default: m = int'($urandom_range(0, 33554431));
        endcase
        t = ($urandom_range(0, 1) == 1) ? picks[$urandom_range(0, 10)] : int'($urandom_range(0, 524287));
        push(m, t, $urandom_range(0, 1) == 1);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      take_cell("random", int'($urandom_range(0, 3)));
    end
  endtask

`ifdef HOG_HIST_INT_EN
  task automatic test_int_round();
    for (int i = 0; i < CELL_PIX; i++) push(32'h18000, 0, 1'b0);
    n_vec++;
    if (get_bin(0) !== 64'd128) begin
      n_err++;
      $display("FAIL int_round_up: got %0d expected 128", get_bin(0));
    end
    take_cell("int_up", 0);
    for (int i = 0; i < CELL_PIX; i++) push(32'h17FFF, 0, 1'b0);
    n_vec++;
    if (get_bin(0) !== 64'd64) begin
      n_err++;
      $display("FAIL int_round_down: got %0d expected 64", get_bin(0));
    end
    take_cell("int_down", 0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_saturated();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef HOG_HIST_INT_EN
    test_int_round();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hog_cell_hist.md
Name: hog_cell_hist

Overview:
- Consumer side of the per-pixel gradient stage. Takes the {magnitude, tan, negative} triple produced for each pixel, converts it to one of 9 unsigned orientation bins (20° each, 0–180°), and accumulates the magnitude into that bin.
- After CELL_PIX accepted samples, it presents the full 9-bin cell histogram to the block-normalisation stage through a valid/ready handshake.

Parameters:
- MAG_I, 9, integer bits of the input magnitude.
- MAG_F, 16, fraction bits of the input magnitude.
- TAN_W, 19, tan width: unsigned, 16 fraction bits, TAN_W-16 integer bits.
- CELL_PIX, 64, samples per cell; must be a power of 2, ≥2.
- Derived localparam: MAG_W = MAG_I+MAG_F.
- Derived localparam: CNT_W = log2(CELL_PIX).
- Derived localparam: HIST_W = MAG_W+CNT_W.

Ports:
- clk, input, 1, clock; all logic on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, sample valid.
- in_ready, output, 1, block can accept a sample.
- magnitude, input, MAG_W, gradient magnitude, unsigned fixed point.
- tan, input, TAN_W, |dy/dx|, unsigned Q(TAN_W-16).16; saturated when dx=0.
- negative, input, 1, gradient angle lies in 90–180°.
- out_valid, output, 1, histogram valid.
- out_ready, input, 1, downstream accepts the histogram.
- hist, output, 9*HIST_W, bin k at [k*HIST_W +: HIST_W], k=0..8.

Behaviour:
- Reset values: all 9 accumulators 0, sample counter 0, state ACCUM, in_ready=1, out_valid=0.
- Reset is asynchronous and takes effect immediately, including mid-cell and in OUTPUT. Partial sums are discarded.
- Binning is combinational on the input triple. Thresholds are Q.16 constants: T20=23853, T40=54991, T60=113512, T80=371673. All comparisons are strict less-than, so tan equal to a threshold falls into the higher-angle side.
- Binning, negative=0: tan<T20 → bin0; <T40 → bin1; <T60 → bin2; <T80 → bin3; else bin4.
- Binning, negative=1: tan<T20 → bin8; <T40 → bin7; <T60 → bin6; <T80 → bin5; else bin4.
- Zero magnitude is still counted as a sample. It adds 0 to its bin.
- State ACCUM: in_ready=1, out_valid=0. On in_valid&in_ready:
  - the selected bin accumulates the zero-extended magnitude on that edge;
  - the counter increments.
  - When the accepted sample is number CELL_PIX (counter == CELL_PIX-1), the counter wraps to 0 and the state moves to OUTPUT on the same edge.
- State OUTPUT: in_ready=0, out_valid=1, hist is stable. hist includes the last sample, so out_valid asserts in the cycle after the final accepted sample.
  - On out_valid&out_ready: all accumulators clear to 0, state returns to ACCUM, and in_ready=1 from the next cycle.
- out_valid, once asserted, stays high with hist unchanged until the handshake completes. in_valid is ignored while in_ready=0.
- Inputs are not registered. The upstream stage holds magnitude, tan and negative stable while in_valid=1 and in_ready=0.
- hist is driven directly from the accumulator registers. hist is don't-care-stable in ACCUM; downstream samples it only when out_valid=1.
- Accumulator overflow is impossible: HIST_W covers CELL_PIX × max magnitude.
- Throughput: one sample per cycle, plus one idle input cycle per cell for the output handshake (more if out_ready is held low).

Optional Feature:
- Macro HOG_HIST_INT_EN.
- Defined:
  - Each magnitude is rounded half-up to an integer before accumulation: (magnitude + 2^(MAG_F-1)) >> MAG_F, saturated to 2^MAG_I-1.
  - HIST_W becomes MAG_I+CNT_W and the hist port narrows to match.
- Undefined: full-precision fixed-point accumulation as described above.

Test Plan:
- 64 samples, magnitude=0x10000 (1.0), tan=0, negative=0, in_valid continuous → out_valid one cycle after the 64th acceptance. bin0=4194304 (0x400000), bins 1–8 = 0, in_ready=0 while out_valid=1.
- Boundary, negative=0: single samples at magnitude 0x10000 with tan = 23852, 23853, 371672, 371673 → bins 0, 1, 3, 4 respectively. Same with negative=1 → bins 8, 7, 5, 4. Pad the rest of the cell with magnitude 0 and check each cell's bin sums.
- Saturated tan=0x7FFFF with negative=1 for all 64 samples, magnitude=0x20000 → bin4=8388608, all other bins 0.
- Backpressure: complete a cell, hold out_ready=0 for 5 cycles while in_valid=1 → hist constant, no sample accepted. Raise out_ready → next cycle in_ready=1, and the new cell starts from all-zero accumulators.
- Reset mid-cell: accept 10 samples into bin2, assert rst for one cycle, then send 64 samples into bin6 at magnitude 0x10000 → bin2=0, bin6=4194304.
- With HOG_HIST_INT_EN defined: 64 samples of magnitude 0x18000 (1.5) into bin0 → bin0=128. Magnitude 0x17FFF → bin0=64.
